// File: rtl/ahb_arb_pkg.sv
// Shared types for the AHB request arbiter.
// State encoding and the requester-count ceiling.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  localparam int MAX_REQ = 4;

endpackage

// File: rtl/ahb_rr_pick.sv
// Round-robin winner search: first set request at or above ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module ahb_rr_pick
  import ahb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_found
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_cand;

  // Scan offsets high to low so the nearest offset from ptr wins last.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(NUM_REQ))
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      w_cand = w_sum[PTR_W-1:0];
      if (i_req[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter sharing one bridge request port among NUM_REQ
// requesters. Optional read timeout enabled by ARB_RD_TIMEOUT_EN.
module ahb_req_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           i_clk_ahb,
  input  logic                           i_rst_ahb,
  input  logic [NUM_REQ-1:0]             i_valid,
  input  logic [NUM_REQ-1:0]             i_rd0_wr1,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_wr_data,
  output logic [NUM_REQ-1:0]             o_ready,
  output logic [NUM_REQ-1:0]             o_rd_valid,
  output logic [DATA_WIDTH-1:0]          o_rd_data,
  output logic [NUM_REQ-1:0]             o_rd_err,
  output logic                           o_valid,
  output logic                           o_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]          o_addr,
  output logic [DATA_WIDTH-1:0]          o_wr_data,
  input  logic                           i_ready,
  input  logic                           i_rd_valid,
  input  logic [DATA_WIDTH-1:0]          i_rd_data,
  output logic                           o_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("ahb_req_arbiter: illegal parameter set");
  end

  arb_state_t             r_state;
  arb_state_t             w_next;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       r_grant;
  logic                   r_rd0_wr1;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wr_data;
  logic [PTR_W-1:0]       w_win;
  logic                   w_found;
  logic                   w_take;
  logic                   w_tmo;
  logic                   w_rd_done;

  ahb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_req   (i_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  assign w_take = (r_state == IDLE) && w_found;

`ifdef ARB_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt;

  // Wait-cycle counter; held at zero outside WAIT_RD so it starts clean.
  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb)
      r_cnt <= '0;
    else if (r_state != WAIT_RD)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign w_tmo = (r_state == WAIT_RD) && !i_rd_valid &&
                 (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  assign w_rd_done = (r_state == WAIT_RD) && (i_rd_valid || w_tmo);

  // State register.
  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_found) w_next = ISSUE;
      ISSUE:   if (i_ready) w_next = r_rd0_wr1 ? IDLE : WAIT_RD;
      WAIT_RD: if (w_rd_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture the winner's request and advance the round-robin pointer.
  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      r_ptr     <= '0;
      r_grant   <= '0;
      r_rd0_wr1 <= 1'b1;
      r_addr    <= '0;
      r_wr_data <= '0;
    end else if (w_take) begin
      r_ptr     <= (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      r_grant   <= w_win;
      r_rd0_wr1 <= i_rd0_wr1[w_win];
      r_addr    <= i_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
      r_wr_data <= i_wr_data[w_win*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Grant and read-return routing; reset masks the grant immediately.
  always_comb begin
    o_ready    = '0;
    o_rd_valid = '0;
    o_rd_err   = '0;
    o_rd_data  = '0;
    if (w_take && !i_rst_ahb)
      o_ready[w_win] = 1'b1;
    if (w_rd_done) begin
      o_rd_valid[r_grant] = 1'b1;
      o_rd_err[r_grant]   = w_tmo;
      if (i_rd_valid)
        o_rd_data = i_rd_data;
    end
  end

  assign o_valid   = (r_state == ISSUE);
  assign o_busy    = (r_state != IDLE);
  assign o_rd0_wr1 = r_rd0_wr1;
  assign o_addr    = r_addr;
  assign o_wr_data = r_wr_data;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Bench for ahb_req_arbiter: directed literal cases plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_ahb_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_RD_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 256;
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [N-1:0]    i_valid;
  logic [N-1:0]    i_rd0_wr1;
  logic [N*AW-1:0] i_addr;
  logic [N*DW-1:0] i_wr_data;
  logic [N-1:0]    o_ready;
  logic [N-1:0]    o_rd_valid;
  logic [DW-1:0]   o_rd_data;
  logic [N-1:0]    o_rd_err;
  logic            o_valid;
  logic            o_rd0_wr1;
  logic [AW-1:0]   o_addr;
  logic [DW-1:0]   o_wr_data;
  logic            i_ready;
  logic            i_rd_valid;
  logic [DW-1:0]   i_rd_data;
  logic            o_busy;

  ahb_req_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk_ahb  (clk),
    .i_rst_ahb  (rst),
    .i_valid    (i_valid),
    .i_rd0_wr1  (i_rd0_wr1),
    .i_addr     (i_addr),
    .i_wr_data  (i_wr_data),
    .o_ready    (o_ready),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .o_rd_err   (o_rd_err),
    .o_valid    (o_valid),
    .o_rd0_wr1  (o_rd0_wr1),
    .o_addr     (o_addr),
    .o_wr_data  (o_wr_data),
    .i_ready    (i_ready),
    .i_rd_valid (i_rd_valid),
    .i_rd_data  (i_rd_data),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic setreq(input int k, input logic v, input logic rw,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_valid[k]            = v;
    i_rd0_wr1[k]          = rw;
    i_addr[k*AW +: AW]    = a;
    i_wr_data[k*DW +: DW] = d;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_rw"}, 64'(o_rd0_wr1), 64'd1);
    chk({tag, "_addr"}, 64'(o_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(o_wr_data), 64'd0);
    chk({tag, "_ready"}, 64'(o_ready), 64'd0);
    chk({tag, "_rdv"}, 64'(o_rd_valid), 64'd0);
    chk({tag, "_rdd"}, 64'(o_rd_data), 64'd0);
    chk({tag, "_err"}, 64'(o_rd_err), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  // Transaction-level reference state.
  int            m_phase;
  int            m_ptr;
  int            m_own;
  int            m_wcnt;
  logic          m_rw;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  bit            pend [N];
  int            granted;
  int            win;
  int            kk;
  bit            done;
  logic [N-1:0]  e_ready;
  logic [N-1:0]  e_rdv;
  logic [N-1:0]  e_err;
  logic [DW-1:0] e_rdd;
  int            order [4];

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    i_valid    = '0;
    i_rd0_wr1  = '0;
    i_addr     = '0;
    i_wr_data  = '0;
    i_ready    = 1'b0;
    i_rd_valid = 1'b0;
    i_rd_data  = '0;
    order[0] = 1; order[1] = 0; order[2] = 1; order[3] = 0;

    // Reset state, with a request already pending.
    setreq(0, 1'b1, 1'b1, 32'h1234, 32'h1);
    repeat (2) @(negedge clk);
    chk_rst("reset");
    i_valid = '0;
    rst = 1'b0;

    // Single write from requester 0.
    @(posedge clk); #1;
    setreq(0, 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF);
    i_ready = 1'b1;
    @(negedge clk);
    chk("wr_ready", 64'(o_ready), 64'h1);
    chk("wr_busy0", 64'(o_busy), 64'h0);
    @(posedge clk); #1;
    i_valid = '0;
    @(negedge clk);
    chk("wr_oval", 64'(o_valid), 64'h1);
    chk("wr_addr", 64'(o_addr), 64'h1000);
    chk("wr_data", 64'(o_wr_data), 64'hDEADBEEF);
    chk("wr_dir", 64'(o_rd0_wr1), 64'h1);
    chk("wr_busy1", 64'(o_busy), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_idle", 64'(o_busy), 64'h0);

    // Both requesters valid; ptr is now 1 so order is 1,0,1,0.
    @(posedge clk); #1;
    setreq(0, 1'b1, 1'b1, 32'h100, 32'hA0);
    setreq(1, 1'b1, 1'b1, 32'h200, 32'hA1);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("rr_ready", 64'(o_ready), 64'(1 << order[t]));
      @(posedge clk); #1;
      @(negedge clk);
      chk("rr_addr", 64'(o_addr), 64'(32'h100 * (order[t] + 1)));
      chk("rr_noready", 64'(o_ready), 64'h0);
      @(posedge clk); #1;
    end
    i_valid = '0;

    // Read by requester 1, data returned in the third wait cycle.
    setreq(1, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("rd_ready", 64'(o_ready), 64'h2);
    @(posedge clk); #1;
    i_valid = '0;
    @(negedge clk);
    chk("rd_addr", 64'(o_addr), 64'h20);
    chk("rd_dir", 64'(o_rd0_wr1), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_w1_rdv", 64'(o_rd_valid), 64'h0);
    chk("rd_w1_oval", 64'(o_valid), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_w2_busy", 64'(o_busy), 64'h1);
    @(posedge clk); #1;
    i_rd_valid = 1'b1;
    i_rd_data  = 32'hCAFE0001;
    @(negedge clk);
    chk("rd_rdv", 64'(o_rd_valid), 64'h2);
    chk("rd_rdd", 64'(o_rd_data), 64'hCAFE0001);
    @(posedge clk); #1;
    i_rd_valid = 1'b0;
    @(negedge clk);
    chk("rd_busy", 64'(o_busy), 64'h0);
    chk("rd_rdd0", 64'(o_rd_data), 64'h0);

    // Downstream stall for 5 cycles; requester 1 waits meanwhile.
    @(posedge clk); #1;
    setreq(0, 1'b1, 1'b1, 32'h3000, 32'h12345678);
    i_ready = 1'b0;
    @(negedge clk);
    chk("st_ready", 64'(o_ready), 64'h1);
    @(posedge clk); #1;
    i_valid[0] = 1'b0;
    setreq(1, 1'b1, 1'b1, 32'h4000, 32'h55);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("st_oval", 64'(o_valid), 64'h1);
      chk("st_addr", 64'(o_addr), 64'h3000);
      chk("st_data", 64'(o_wr_data), 64'h12345678);
      chk("st_ready0", 64'(o_ready), 64'h0);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    @(negedge clk);
    chk("st_oval_end", 64'(o_valid), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("st_pending", 64'(o_ready), 64'h2);
    @(posedge clk); #1;
    i_valid = '0;
    @(negedge clk);
    chk("st_addr2", 64'(o_addr), 64'h4000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("st_idle", 64'(o_busy), 64'h0);

    // Reset asserted mid-read, then a stray read return.
    @(posedge clk); #1;
    setreq(0, 1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    chk("mr_ready", 64'(o_ready), 64'h1);
    @(posedge clk); #1;
    i_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_wait", 64'(o_busy), 64'h1);
    #2 rst = 1'b1;
    #1 chk_rst("mr_async");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    i_rd_valid = 1'b1;
    i_rd_data  = 32'hBAD0BAD0;
    @(negedge clk);
    chk("mr_stray_rdv", 64'(o_rd_valid), 64'h0);
    chk("mr_stray_rdd", 64'(o_rd_data), 64'h0);
    chk("mr_stray_busy", 64'(o_busy), 64'h0);
    @(posedge clk); #1;
    i_rd_valid = 1'b0;

`ifdef ARB_RD_TIMEOUT_EN
    // Read that never returns: error in the 8th wait cycle.
    setreq(0, 1'b1, 1'b0, 32'h88, 32'h0);
    i_ready = 1'b1;
    @(negedge clk);
    chk("to_ready", 64'(o_ready), 64'h1);
    @(posedge clk); #1;
    i_valid = '0;
    @(posedge clk); #1;
    for (int w = 1; w <= 8; w++) begin
      @(negedge clk);
      if (w < 8) begin
        chk("to_rdv_early", 64'(o_rd_valid), 64'h0);
        chk("to_err_early", 64'(o_rd_err), 64'h0);
      end else begin
        chk("to_rdv", 64'(o_rd_valid), 64'h1);
        chk("to_err", 64'(o_rd_err), 64'h1);
        chk("to_rdd", 64'(o_rd_data), 64'h0);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_idle", 64'(o_busy), 64'h0);
    @(posedge clk); #1;
`endif

    // Randomized traffic against the reference model.
    rst = 1'b1;
    i_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    m_phase = 0;
    m_ptr   = 0;
    m_own   = 0;
    m_wcnt  = 0;
    m_rw    = 1'b1;
    m_a     = '0;
    m_d     = '0;
    granted = -1;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (granted == k) pend[k] = 1'b0;
        if (!pend[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            setreq(k, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            pend[k] = 1'b1;
          end else begin
            i_valid[k] = 1'b0;
          end
        end
      end
      i_ready    = 1'($urandom_range(0, 1));
      i_rd_valid = ($urandom_range(0, 3) == 0);
      i_rd_data  = $urandom;
      @(negedge clk);

      win = -1;
      if (m_phase == 0) begin
        for (int i = 0; i < N; i++) begin
          kk = (m_ptr + i) % N;
          if (win < 0 && i_valid[kk]) win = kk;
        end
      end
      e_ready = '0;
      if (win >= 0) e_ready[win] = 1'b1;
      e_rdv = '0;
      e_err = '0;
      e_rdd = '0;
      done  = 1'b0;
      if (m_phase == 2) begin
        if (i_rd_valid) begin
          e_rdv[m_own] = 1'b1;
          e_rdd = i_rd_data;
          done = 1'b1;
        end else if (TO_EN && m_wcnt == TO - 1) begin
          e_rdv[m_own] = 1'b1;
          e_err[m_own] = 1'b1;
          done = 1'b1;
        end
      end
      chk("m_ready", 64'(o_ready), 64'(e_ready));
      chk("m_oval", 64'(o_valid), 64'(m_phase == 1));
      chk("m_busy", 64'(o_busy), 64'(m_phase != 0));
      chk("m_rdv", 64'(o_rd_valid), 64'(e_rdv));
      chk("m_rdd", 64'(o_rd_data), 64'(e_rdd));
      chk("m_err", 64'(o_rd_err), 64'(e_err));
      if (m_phase == 1) begin
        chk("m_addr", 64'(o_addr), 64'(m_a));
        chk("m_wdata", 64'(o_wr_data), 64'(m_d));
        chk("m_dir", 64'(o_rd0_wr1), 64'(m_rw));
      end

      granted = win;
      if (m_phase == 0) begin
        if (win >= 0) begin
          m_own   = win;
          m_rw    = i_rd0_wr1[win];
          m_a     = i_addr[win*AW +: AW];
          m_d     = i_wr_data[win*DW +: DW];
          m_ptr   = (win + 1) % N;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (i_ready) begin
          m_phase = m_rw ? 0 : 2;
          m_wcnt  = 0;
        end
      end else begin
        if (done) m_phase = 0;
        else m_wcnt++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
